// File: rtl/riscv_pkg.sv
// Shared RV32 fetch types: NOP encoding, fetch FSM states and the IF/ID register layout.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013; // addi x0, x0, 0

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    localparam int    IFID_W      = $bits(ifid_t);
    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, valid: 1'b0};

    function automatic ifid_t make_ifid(input logic [XLEN-1:0] instr, input logic [XLEN-1:0] pc);
        ifid_t e;
        e.instr    = instr;
        e.pc       = pc;
        e.pc_plus4 = pc + XLEN'(4);
        e.valid    = 1'b1;
        return e;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding slot for a fetch response that lands while decode is stalled.
// Entry readable the cycle after write; clear beats write, write beats read.
module fetch_hold_buf import riscv_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [IFID_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic              clr_i,
    output logic              full_o,
    output logic [IFID_W-1:0] rd_dat_o
);

    logic              full_q, full_d;
    logic [IFID_W-1:0] dat_q, dat_d;

    always_comb begin
        full_d = full_q;
        dat_d  = dat_q;
        if (clr_i) begin
            full_d = 1'b0;
        end else if (wr_en_i) begin
            full_d = 1'b1;
            dat_d  = wr_dat_i;
        end else if (rd_en_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else begin
            full_q <= full_d;
            dat_q  <= dat_d;
        end
    end

    assign full_o   = full_q;
    assign rd_dat_o = dat_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, redirect kill, 1-entry decode-stall hold buffer.
// Optional FETCH_STALL_COUNT_EN adds a saturating 32-bit stall_cnt output.
module fetch_stage import riscv_pkg::*; #(
    parameter int                     DATA_LENGTH = 32,
    parameter logic [DATA_LENGTH-1:0] RESET_PC    = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_f,
    input  logic                   stall_d,
    input  logic                   flush_d,
    input  logic                   pc_src_e,
    input  logic [DATA_LENGTH-1:0] pc_target_e,
    output logic                   imem_req,
    output logic [DATA_LENGTH-1:0] imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [DATA_LENGTH-1:0] imem_rdata,
    output logic [DATA_LENGTH-1:0] instr_d,
    output logic [DATA_LENGTH-1:0] pc_d,
    output logic [DATA_LENGTH-1:0] pc_plus4_d,
    output logic                   valid_d
`ifdef FETCH_STALL_COUNT_EN
    ,
    output logic [31:0]            stall_cnt
`endif
);

    fetch_state_e           state_q;
    logic [DATA_LENGTH-1:0] pc_f_q, pc_f_d;
    logic [DATA_LENGTH-1:0] req_pc_q;
    logic                   kill_q, kill_d;
    ifid_t                  ifid_q, ifid_d;
    ifid_t                  resp_ent;
    logic                   accept, resp, resp_live;
    logic                   buf_full, buf_wr, buf_rd;
    logic [IFID_W-1:0]      buf_rd_dat;

    assign imem_req  = (state_q == FS_REQ) && !stall_f && !buf_full;
    assign imem_addr = pc_f_q;
    assign accept    = imem_req && imem_ready;
    assign resp      = (state_q == FS_WAIT) && imem_rvalid;
    // A response racing a redirect is wrong-path even if no kill was recorded yet.
    assign resp_live = resp && !kill_q && !pc_src_e;
    assign resp_ent  = make_ifid(imem_rdata, req_pc_q);
    assign buf_wr    = resp_live && stall_d && !flush_d;
    assign buf_rd    = buf_full && !stall_d && !flush_d && !pc_src_e;

    fetch_hold_buf u_hold (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (buf_wr),
        .wr_dat_i (resp_ent),
        .rd_en_i  (buf_rd),
        .clr_i    (pc_src_e),
        .full_o   (buf_full),
        .rd_dat_o (buf_rd_dat)
    );

    always_comb begin
        pc_f_d = pc_f_q;
        if (pc_src_e) begin
            pc_f_d = pc_target_e;
        end else if (accept) begin
            pc_f_d = pc_f_q + DATA_LENGTH'(4);
        end
    end

    always_comb begin
        kill_d = kill_q;
        if (pc_src_e && (accept || ((state_q == FS_WAIT) && !imem_rvalid))) begin
            kill_d = 1'b1;
        end else if (resp) begin
            kill_d = 1'b0;
        end
    end

    always_comb begin
        ifid_d = ifid_q;
        if (flush_d) begin
            ifid_d = IFID_BUBBLE;
        end else if (!stall_d) begin
            if (buf_rd) begin
                ifid_d = ifid_t'(buf_rd_dat);
            end else if (resp_live) begin
                ifid_d = resp_ent;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FS_IDLE;
            pc_f_q   <= RESET_PC;
            req_pc_q <= RESET_PC;
            kill_q   <= 1'b0;
            ifid_q   <= IFID_BUBBLE;
        end else begin
            unique case (state_q)
                FS_IDLE: state_q <= FS_REQ;
                FS_REQ:  if (accept) state_q <= FS_WAIT;
                FS_WAIT: if (imem_rvalid) state_q <= FS_REQ;
                default: state_q <= FS_IDLE;
            endcase
            pc_f_q <= pc_f_d;
            kill_q <= kill_d;
            ifid_q <= ifid_d;
            if (accept) begin
                req_pc_q <= pc_f_q;
            end
        end
    end

    assign instr_d    = ifid_q.instr;
    assign pc_d       = ifid_q.pc;
    assign pc_plus4_d = ifid_q.pc_plus4;
    assign valid_d    = ifid_q.valid;

`ifdef FETCH_STALL_COUNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((stall_f || stall_d) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 32, datapath and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stall_f  input  1  hold PC; no new imem request issued.
REQ-006 SHALL have port stall_d  input  1  hold IF/ID register contents.
REQ-007 SHALL have port flush_d  input  1  replace IF/ID contents with bubble.
REQ-008 SHALL have port pc_src_e  input  1  taken branch/jump redirect from execute.
REQ-009 SHALL have port pc_target_e  input  DATA_LENGTH  redirect address.
REQ-010 SHALL have port imem_req  output  1  instruction fetch request valid.
REQ-011 SHALL have port imem_addr  output  DATA_LENGTH  fetch address, equals pc_f.
REQ-012 SHALL have port imem_ready  input  1  request accepted when imem_req & imem_ready.
REQ-013 SHALL have port imem_rvalid  input  1  response valid, any cycle after acceptance.
REQ-014 SHALL have port imem_rdata  input  DATA_LENGTH  fetched instruction.
REQ-015 SHALL have ports instr_d, pc_d, pc_plus4_d  output  DATA_LENGTH  IF/ID register to decode.
REQ-016 SHALL have port valid_d  output  1  IF/ID holds a real instruction.

Function
REQ-017 SHALL implement FSM IDLE -> REQ -> WAIT -> REQ; IDLE lasts exactly one cycle after reset release.
REQ-018 SHALL assert imem_req only in REQ with stall_f low and hold buffer empty.
REQ-019 SHALL move REQ -> WAIT and set pc_f <= pc_f + 4 on acceptance; at most one request outstanding.
REQ-020 SHALL move WAIT -> REQ on imem_rvalid, same cycle response is consumed.
REQ-021 SHALL load IF/ID with {imem_rdata, fetched pc, pc + 4, valid 1} on a non-killed response when stall_d low.
REQ-022 SHALL store a non-killed response arriving with stall_d high in a 1-entry hold buffer; buffer drains to IF/ID on first cycle stall_d low.
REQ-023 SHALL, on pc_src_e, set pc_f <= pc_target_e, clear hold buffer, and set kill flag if a request is outstanding.
REQ-024 SHALL discard the response matching a killed request and clear the kill flag; IF/ID unchanged by it.
REQ-025 SHALL give pc_src_e priority over stall_f for the PC update.
REQ-026 SHALL load IF/ID with bubble (instr 32'h0000_0013, pc 0, pc_plus4 0, valid 0) on flush_d; flush_d beats stall_d and any response.
REQ-027 SHALL hold IF/ID unchanged when stall_d high and flush_d low.
REQ-028 SHALL wrap pc_f + 4 modulo 2^DATA_LENGTH without error.
REQ-029 SHALL keep IF/ID unchanged (not bubble) when no response arrives and no flush.

Reset
REQ-030 SHALL on rst: pc_f = RESET_PC, state IDLE, kill 0, hold buffer empty, IF/ID = bubble, imem_req 0.
REQ-031 SHALL, on reset mid-request, ignore any later response until a new request is accepted.

Configuration
REQ-032 SHALL, with FETCH_STALL_COUNT_EN defined, add output stall_cnt (32 bits), incremented each cycle stall_f or stall_d high, saturating at all-ones, reset to 0.
REQ-033 SHALL, without FETCH_STALL_COUNT_EN, omit stall_cnt port and counter logic entirely.

Structure
REQ-034 SHALL take NOP encoding, FSM state enum and IF/ID struct typedef from shared package riscv_pkg.
REQ-035 SHALL implement the hold buffer as sub-module fetch_hold_buf (1-entry, write/read/clear).

Verification
REQ-036 SHALL cover: reset release, imem_ready=1, 1-cycle rvalid -> addresses 0,4,8 issued, instr_d follows each response one cycle later, valid_d 1.
REQ-037 SHALL cover: stall_d high 3 cycles when response for pc 8 arrives -> IF/ID holds pc 4, then shows pc 8 first cycle stall_d low, no request issued while buffer full.
REQ-038 SHALL cover: pc_src_e=1, pc_target_e=32'h100 while request for pc 12 outstanding -> pc 12 response dropped, next imem_addr 32'h100.
REQ-039 SHALL cover: flush_d and stall_d high with response -> instr_d 32'h0000_0013, valid_d 0.
REQ-040 SHALL cover: RESET_PC 32'hFFFF_FFFC -> second fetch address 32'h0000_0000.
REQ-041 SHALL cover: rst asserted in WAIT, late rvalid after release -> IF/ID stays bubble, first fetch RESET_PC.
